// File: rtl/text_pkg.sv
// Shared definitions for the on-screen text layer: cell word layout, font geometry and
// the default text grid size. Used by the renderer and by the text writer blocks.
package text_pkg;

    // Cell word layout: bit 8 = valid, bit 7 = blink attribute, bits 5:0 = glyph code
    localparam int unsigned CELL_VALID_BIT = 8;
    localparam int unsigned BLINK_BIT      = 7;
    localparam int unsigned GLYPH_W        = 6;
    localparam int unsigned FONT_ROW_W     = 8;

    // Default text grid
    localparam int unsigned TEXT_COLS = 40;
    localparam int unsigned TEXT_ROWS = 30;

    // Linear cell address; cols is a constant at every call site so the multiply folds
    function automatic logic [15:0] cell_addr(input logic [15:0] row,
                                              input logic [15:0] col,
                                              input int unsigned cols = TEXT_COLS);
        logic [31:0] sum;
        sum = 32'(row) * cols + 32'(col);
        return sum[15:0];
    endfunction

endpackage

// File: rtl/text_sync_delay.sv
// Strobe-gated delay line for the raster timing flags (active/hsync/vsync), so they
// leave the renderer on the same strobe as the matching text pixel.
module text_sync_delay #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAGES = 3   // must be 2 or more
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe_q;

    // Shift one stage per strobe; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (stb) begin
            pipe_q <= {pipe_q[STAGES-2:0], d};
        end
    end

    assign q = pipe_q[STAGES-1];

endmodule

// File: rtl/text_layer_renderer.sv
// Text layer renderer: looks up the text cell under the beam, fetches the glyph row from
// the font ROM and emits one text pixel per strobe, 3 strobes after the beam position,
// with active/hsync/vsync delayed to match.
// Optional macro TEXT_BLINK_EN: bit 7 of a cell word makes it blink (32 frames on, 32 off).
module text_layer_renderer
    import text_pkg::*;
#(
    parameter int unsigned COLS       = TEXT_COLS,
    parameter int unsigned ROWS       = TEXT_ROWS,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned XW         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_stb,
    input  logic [XW-1:0]         x_in,
    input  logic [XW-1:0]         y_in,
    input  logic                  active_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [15:0]           ram_addr,
    input  logic [15:0]           ram_dout,
    output logic [GLYPH_W+2:0]    font_addr,
    input  logic [FONT_ROW_W-1:0] font_row,
    output logic                  text_on,
    output logic                  active_out,
    output logic                  hsync_out,
    output logic                  vsync_out
);

    localparam int unsigned CELL_SHIFT = 3 + SCALE_LOG2;

    logic [XW-1:0]      col;
    logic [XW-1:0]      row;
    logic               in_grid_d;
    logic [15:0]        addr_d;
    logic [2:0]         xsub_d;
    logic [2:0]         ysub_d;

    logic [15:0]        addr_q;
    logic               in_grid_q;
    logic [2:0]         xsub_q;
    logic [2:0]         ysub_q;

    logic               cell_valid_d;
    logic [GLYPH_W+2:0] font_addr_d;
    logic [2:0]         bit_idx_d;
    logic               blink_dark;

    logic               cell_valid_q;
    logic [GLYPH_W+2:0] font_addr_q;
    logic [2:0]         bit_idx_q;

    logic               text_on_q;
    logic [2:0]         sync_q;
    logic               unused_bits;

    // Only some bits of the cell word and of the beam coordinates matter
    assign unused_bits = ^{ram_dout, x_in, y_in};

    // S0 combinational: beam position to cell address and in-grid flag
    always_comb begin
        col       = x_in >> CELL_SHIFT;
        row       = y_in >> CELL_SHIFT;
        in_grid_d = active_in & (32'(col) < COLS) & (32'(row) < ROWS);
        addr_d    = cell_addr(16'(row), 16'(col), COLS);
        xsub_d    = 3'(x_in >> SCALE_LOG2);
        ysub_d    = 3'(y_in >> SCALE_LOG2);
    end

    // S0 registers: address goes straight out to the text RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            in_grid_q <= 1'b0;
            xsub_q    <= '0;
            ysub_q    <= '0;
        end else if (pix_stb) begin
            addr_q    <= addr_d;
            in_grid_q <= in_grid_d;
            xsub_q    <= xsub_d;
            ysub_q    <= ysub_d;
        end
    end

`ifdef TEXT_BLINK_EN
    logic [5:0] frame_cnt_q;
    logic       vsync_prev_q;

    // Frame counter: one count per vsync rising edge seen on strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            vsync_prev_q <= 1'b0;
        end else if (pix_stb) begin
            vsync_prev_q <= vsync_in;
            if (vsync_in && !vsync_prev_q) begin
                frame_cnt_q <= frame_cnt_q + 6'd1;
            end
        end
    end

    assign blink_dark = ram_dout[BLINK_BIT] & frame_cnt_q[5];
`else
    assign blink_dark = 1'b0;
`endif

    // S1 combinational: cell word to font address; out-of-grid results are masked here
    always_comb begin
        cell_valid_d = ram_dout[CELL_VALID_BIT] & in_grid_q & ~blink_dark;
        font_addr_d  = {ram_dout[GLYPH_W-1:0], ysub_q};
        bit_idx_d    = 3'd7 - xsub_q;
    end

    // S1 registers: font address goes straight out to the font ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_valid_q <= 1'b0;
            font_addr_q  <= '0;
            bit_idx_q    <= '0;
        end else if (pix_stb) begin
            cell_valid_q <= cell_valid_d;
            font_addr_q  <= font_addr_d;
            bit_idx_q    <= bit_idx_d;
        end
    end

    // S2 register: pick the glyph pixel out of the font row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_on_q <= 1'b0;
        end else if (pix_stb) begin
            text_on_q <= cell_valid_q & font_row[bit_idx_q];
        end
    end

    text_sync_delay #(
        .WIDTH  (3),
        .STAGES (3)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .stb   (pix_stb),
        .d     ({active_in, hsync_in, vsync_in}),
        .q     (sync_q)
    );

    assign ram_addr   = addr_q;
    assign font_addr  = font_addr_q;
    assign text_on    = text_on_q;
    assign active_out = sync_q[2];
    assign hsync_out  = sync_q[1];
    assign vsync_out  = sync_q[0];

endmodule
